rip_fifo_unpack: RTL
====================

# rip_fifo_unpack

Read-side consumer for the team's asynchronous FIFO. Runs in the FIFO's read-clock domain, pops wide entries through the FIFO's show-ahead read port and emits them as a stream of narrow words on a valid/ready interface toward the core. It sustains one narrow word per cycle, including across entry boundaries, with no bubbles.

## Interface
- `IN_WIDTH`, default 128: width of one FIFO entry.
- `OUT_WIDTH`, default 32: width of one output word.
- `LANES`, derived as IN_WIDTH/OUT_WIDTH: lanes per entry.
  - Elaboration error unless IN_WIDTH % OUT_WIDTH == 0 and LANES >= 2.

Ports:
- `clk`  in  1: single clock, the FIFO read clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `f_r_data`  in  IN_WIDTH: FIFO head entry, show-ahead (valid while f_r_empty=0).
- `f_r_empty`  in  1: FIFO empty.
- `f_r_en`  out  1: FIFO pop strobe.
- `flush`  in  1: discard the buffered entry.
- `m_valid`  out  1: output word valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  OUT_WIDTH: output word.
- `m_last`  out  1: word is the final lane of its entry.

## Operation
- State: `buf` (IN_WIDTH), `buf_valid`, `lane` (clog2(LANES) bits). Two-state FSM:
  - EMPTY is buf_valid=0.
  - DRAIN is buf_valid=1.
- Handshake: `hs = m_valid & m_ready`.
- `pop = rst_n & !f_r_empty & !flush & (!buf_valid | (hs & lane==LANES-1))`.
  - `f_r_en = pop`, combinational.
  - f_r_en must be 0 while rst_n is low.
- Pop cycle:
  - `buf <= f_r_data`, `buf_valid <= 1`, `lane <= 0`.
  - The FIFO's show-ahead data is captured in the same cycle as f_r_en.
- On hs without pop:
  - If lane < LANES-1: `lane <= lane+1`.
  - Else: `buf_valid <= 0`, `lane <= 0`.
  - This is the transition DRAIN→EMPTY.
- `m_valid = buf_valid`.
- `m_data` = lane `lane` of `buf` (lane order per Configuration).
- `m_last = buf_valid & lane==LANES-1`.
- m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- Flush:
  - Next cycle: `buf_valid <= 0`, `lane <= 0`. No pop in the flush cycle.
  - A handshake coinciding with flush still counts as delivered.
  - Flush does not drain the FIFO. Entries still in the FIFO are popped normally from the cycle after flush deasserts.
- Lane counter never exceeds LANES-1 and wraps to 0 only on pop, on last-lane handshake, or on flush.

## Timing
- Reset values:
  - m_valid=0, m_data=0, m_last=0, f_r_en=0.
  - buf=0, buf_valid=0, lane=0.
- Latency: the FIFO goes non-empty in cycle N with the block in EMPTY → f_r_en=1 in N → m_valid=1 from N+1.
- Throughput:
  - With m_ready held high and the FIFO never empty, one word per cycle.
  - The last-lane handshake and the next pop occur in the same cycle, so the next entry's lane 0 appears the following cycle.
- Backpressure:
  - With m_ready=0, no pop occurs once the block is in DRAIN.
  - The FIFO absorbs the stall.
- Reset asserted mid-entry:
  - The block returns immediately (asynchronously) to EMPTY with f_r_en=0.
  - The partial entry is lost.
  - The FIFO read pointer is untouched by this block. Reset of the FIFO read side is owned by the FIFO.

## Configuration
- Macro `RIP_FIFO_UNPACK_MSB_FIRST_EN`.
- Undefined: lane k = `buf[k*OUT_WIDTH +: OUT_WIDTH]`, so the least-significant word is emitted first.
- Defined: lane k = `buf[(LANES-1-k)*OUT_WIDTH +: OUT_WIDTH]`, so the most-significant word is emitted first.
- Handshake, latency and m_last are identical in both builds.

## Structure
- Shared package `rip_fifo_pkg` holds:
  - the FSM state enum `{UNPACK_EMPTY, UNPACK_DRAIN}`;
  - default width constants (128/32).
- The lane index type is declared locally from LANES.
- One sub-module, `rip_lane_select` (parameters IN_WIDTH, OUT_WIDTH):
  - purely combinational word mux;
  - the lane-order macro is applied only inside it.

## Test plan
- Reset then single entry: with rst_n low and FIFO non-empty, f_r_en=0. Release reset and push 0x44444444_33333333_22222222_11111111 with m_ready=1 → m_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles. m_last=1 only on the fourth word; exactly one f_r_en pulse.
- Back-to-back: push 3 entries, m_ready=1 → 12 consecutive valid cycles with no gaps. f_r_en pulses in the cycles of words 4 and 8.
- Backpressure: m_ready toggles 1,0,0,1,… → each word is held stable while stalled. No f_r_en while buf_valid=1 except on the last-lane handshake. Output order is unchanged.
- Flush mid-entry: assert flush after 2 words of entry A, with entry B queued → lanes 2–3 of A are never emitted. m_valid=0 in the cycle after flush. B's lane 0 is emitted two cycles after flush.
- Reset mid-entry: rst_n low after lane 1 → m_valid, m_data, m_last and f_r_en go to 0 immediately.
- MSB-first build: rerun the first scenario with `RIP_FIFO_UNPACK_MSB_FIRST_EN` defined → 0x44444444 is emitted first, 0x11111111 last.

Source files
------------

// File: rtl/rip_fifo_pkg.sv
// rip_fifo_pkg: shared FSM state and default widths for the rip FIFO read side
package rip_fifo_pkg;
    typedef enum logic {UNPACK_EMPTY, UNPACK_DRAIN} unpack_state_e;
    localparam int UNPACK_IN_WIDTH = 128;
    localparam int UNPACK_OUT_WIDTH = 32;
endpackage

// File: rtl/rip_lane_select.sv
// rip_lane_select: combinational word mux; RIP_FIFO_UNPACK_MSB_FIRST_EN selects MSB-first lane order
module rip_lane_select #(
    parameter int IN_WIDTH = 128,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]                   data,
    input  logic [$clog2(IN_WIDTH/OUT_WIDTH)-1:0] lane,
    output logic [OUT_WIDTH-1:0]                  word
);
    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    always_comb begin
        word = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef RIP_FIFO_UNPACK_MSB_FIRST_EN
            if (int'(lane) == k) word = data[(LANES-1-k)*OUT_WIDTH +: OUT_WIDTH];
`else
            if (int'(lane) == k) word = data[k*OUT_WIDTH +: OUT_WIDTH];
`endif
        end
    end
endmodule

// File: rtl/rip_fifo_unpack.sv
// rip_fifo_unpack: pops wide show-ahead FIFO entries and streams them as narrow words; lane order via RIP_FIFO_UNPACK_MSB_FIRST_EN
module rip_fifo_unpack
    import rip_fifo_pkg::*;
#(
    parameter int IN_WIDTH = UNPACK_IN_WIDTH,
    parameter int OUT_WIDTH = UNPACK_OUT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  f_r_data,
    input  logic                 f_r_empty,
    output logic                 f_r_en,
    input  logic                 flush,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_last
);
    localparam int LANES = IN_WIDTH / OUT_WIDTH;
    localparam int LW = $clog2(LANES);
    typedef logic [LW-1:0] lane_t;
    localparam lane_t LAST_LANE = lane_t'(LANES - 1);

    if (IN_WIDTH % OUT_WIDTH != 0 || LANES < 2) begin : g_bad_width
        $error("rip_fifo_unpack: IN_WIDTH must be a multiple of OUT_WIDTH with at least 2 lanes");
    end

    unpack_state_e         state_q, state_d;
    logic [IN_WIDTH-1:0]   data_q, data_d;
    lane_t                 lane_q, lane_d;
    logic                  hs, last, pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNPACK_EMPTY;
            data_q  <= '0;
            lane_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            lane_q  <= lane_d;
        end
    end

    // The last-lane handshake and the next pop share a cycle, so entries stream without bubbles.
    always_comb begin
        hs = m_valid & m_ready;
        last = lane_q == LAST_LANE;
        pop = rst_n & ~f_r_empty & ~flush & (state_q == UNPACK_EMPTY | (hs & last));
        data_d = pop ? f_r_data : data_q;
        state_d = state_q;
        lane_d = lane_q;
        if (flush) begin
            state_d = UNPACK_EMPTY;
            lane_d = '0;
        end else if (pop) begin
            state_d = UNPACK_DRAIN;
            lane_d = '0;
        end else if (hs) begin
            state_d = last ? UNPACK_EMPTY : UNPACK_DRAIN;
            lane_d = last ? '0 : lane_q + 1'b1;
        end
    end

    assign f_r_en = pop;
    assign m_valid = state_q == UNPACK_DRAIN;
    assign m_last = m_valid & last;

    rip_lane_select #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane_select (
        .data (data_q),
        .lane (lane_q),
        .word (m_data)
    );
endmodule
